// File: rtl/queue_call_dispatcher.sv
// rtl/queue_call_dispatcher.sv - ticket issue FIFO with round-robin counter call dispatch
module queue_call_dispatcher #(
    parameter int NUM_COUNTERS = 5,
    parameter int TICKET_W     = 6,
    parameter int MAX_TICKET   = 63,
    parameter int DEPTH        = 16,
    parameter int IDX_W        = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             button,
    input  logic [NUM_COUNTERS-1:0]          counter_req,
    output logic [TICKET_W-1:0]              current_number,
    output logic                             issue,
    output logic                             reject,
    output logic [$clog2(DEPTH+1)-1:0]       waiting,
    output logic                             full,
    output logic                             call_valid,
    output logic [IDX_W-1:0]                 call_counter,
    output logic [TICKET_W-1:0]              call_number,
    output logic [NUM_COUNTERS*TICKET_W-1:0] serving_numbers
);
    localparam int WAIT_W = $clog2(DEPTH + 1);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                    btn_meta_q, btn_meta_d;
    logic                    btn_sync_q, btn_sync_d;
    logic                    btn_prev_q, btn_prev_d;
    logic [TICKET_W-1:0]     current_q, current_d;
    logic                    issue_q, issue_d;
    logic                    reject_q, reject_d;
    logic [WAIT_W-1:0]       waiting_q, waiting_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [NUM_COUNTERS-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic                    call_valid_q, call_valid_d;
    logic [IDX_W-1:0]        call_counter_q, call_counter_d;
    logic [TICKET_W-1:0]     call_number_q, call_number_d;
    logic [TICKET_W-1:0]     serving_q [NUM_COUNTERS];
    logic [TICKET_W-1:0]     serving_d [NUM_COUNTERS];
    logic [TICKET_W-1:0]     mem_q [DEPTH];

    logic                    press, deq, enq, is_full;
    logic [TICKET_W-1:0]     next_ticket;
    logic                    hi_found, lo_found;
    logic [IDX_W-1:0]        hi_idx, lo_idx, grant;
    logic [NUM_COUNTERS-1:0] grant_mask;

    always_comb begin
        btn_meta_d = button;
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;
        press      = btn_sync_q & ~btn_prev_q;
        is_full    = (waiting_q == WAIT_W'(DEPTH));
        deq        = (waiting_q != '0) && (pending_q != '0);
        // A dequeue on the same edge frees the slot, so a full queue still accepts.
        enq        = press && (!is_full || deq);
        next_ticket = (current_q == '0 || current_q == TICKET_W'(MAX_TICKET)) ?
                      TICKET_W'(1) : current_q + 1'b1;

        // Descending scan: the last hit is the lowest index; hi_* restricts to >= rr.
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_COUNTERS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
                if (IDX_W'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        grant = hi_found ? hi_idx : lo_idx;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            grant_mask[i] = deq && lo_found && (grant == IDX_W'(i));
        end

        current_d      = enq ? next_ticket : current_q;
        wr_ptr_d       = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        issue_d        = enq;
        reject_d       = press && !enq;
        call_valid_d   = deq;
        call_counter_d = call_counter_q;
        call_number_d  = call_number_q;
        rd_ptr_d       = rd_ptr_q;
        rr_d           = rr_q;
        serving_d      = serving_q;
        if (deq) begin
            call_counter_d = grant;
            call_number_d  = mem_q[rd_ptr_q];
            rd_ptr_d       = rd_ptr_q + 1'b1;
            rr_d           = (grant == IDX_W'(NUM_COUNTERS - 1)) ? '0 : grant + 1'b1;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (grant_mask[i]) serving_d[i] = mem_q[rd_ptr_q];
            end
        end
        // Clearing the granted bit wins over a request still held on that edge.
        pending_d = (pending_q | counter_req) & ~grant_mask;

        waiting_d = waiting_q;
        if (enq && !deq)      waiting_d = waiting_q + 1'b1;
        else if (deq && !enq) waiting_d = waiting_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta_q     <= 1'b0;
            btn_sync_q     <= 1'b0;
            btn_prev_q     <= 1'b0;
            current_q      <= '0;
            issue_q        <= 1'b0;
            reject_q       <= 1'b0;
            waiting_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pending_q      <= '0;
            rr_q           <= '0;
            call_valid_q   <= 1'b0;
            call_counter_q <= '0;
            call_number_q  <= '0;
            for (int i = 0; i < NUM_COUNTERS; i++) serving_q[i] <= '0;
        end else begin
            btn_meta_q     <= btn_meta_d;
            btn_sync_q     <= btn_sync_d;
            btn_prev_q     <= btn_prev_d;
            current_q      <= current_d;
            issue_q        <= issue_d;
            reject_q       <= reject_d;
            waiting_q      <= waiting_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            pending_q      <= pending_d;
            rr_q           <= rr_d;
            call_valid_q   <= call_valid_d;
            call_counter_q <= call_counter_d;
            call_number_q  <= call_number_d;
            serving_q      <= serving_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= next_ticket;
    end

    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            serving_numbers[i*TICKET_W +: TICKET_W] = serving_q[i];
        end
    end

    assign current_number = current_q;
    assign issue          = issue_q;
    assign reject         = reject_q;
    assign waiting        = waiting_q;
    assign full           = is_full;
    assign call_valid     = call_valid_q;
    assign call_counter   = call_counter_q;
    assign call_number    = call_number_q;
endmodule
